alu_bist: RTL and testbench
===========================

# alu_bist

Built-in self-test sequencer for the single-cycle core's ALU. It drives the ALU's operand and control inputs with a pseudo-random vector stream across every implemented opcode. Each returned result and its Zero/Sign flags are compressed into a 32-bit MISR signature. It sits beside the datapath and owns the ALU inputs only while a test runs, via an external mux selected by `busy`.

## Interface
Parameters:
- NUM_VECTORS, 64, vectors applied per opcode (≥1)
- SEED, 32'hACE1_2345, operand LFSR seed (nonzero)
- GOLDEN_SIG, 32'h0000_0000, expected final signature (used only with ALU_BIST_CHECK_EN)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level-sampled request to begin a test
- busy  out  1  high while vectors are being applied
- done  out  1  high when a test has finished; held until next start or reset
- alu_a  out  32  ALU operand A
- alu_b  out  32  ALU operand B
- alu_ctrl  out  3  ALU operation select
- alu_result  in  32  ALU result, combinational from alu_a/alu_b/alu_ctrl
- alu_zero  in  1  ALU Zero flag
- alu_sign  in  1  ALU Sign flag
- signature  out  32  MISR contents; stable when done=1
- pass  out  1  signature equals GOLDEN_SIG (see Configuration)

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on start=1.
  - RUN → DONE after the last vector.
  - DONE → RUN on start=1.
  - start is ignored in RUN.
- On entering RUN:
  - lfsr←SEED, signature←0, op index←0, vector count←0, done←0, pass←0.
- Opcode order: 000 (add), 001 (sll), 010 (sub), 100 (xor), 101 (srl), 110 (or), 111 (and).
  - 011 is never issued.
  - 7 opcodes, NUM_VECTORS vectors each.
- Vector for a RUN cycle:
  - alu_a = lfsr.
  - For ops 001 and 101: alu_b = {27'b0, lfsr[4:0]}.
  - For all other ops: alu_b = {lfsr[15:0], lfsr[31:16]}.
  - alu_ctrl = current op.
- LFSR: 32-bit Galois, shift left, feedback mask 32'h0040_0007 XORed when the bit shifted out (lfsr[31]) is 1. Advances once per RUN cycle.
- MISR update each RUN cycle:
  - sig_next = ({sig[30:0],1'b0} ^ (sig[31] ? 32'h0040_0007 : 0)) ^ alu_result ^ {30'b0, alu_sign, alu_zero}.
- Vector count:
  - Width $clog2(NUM_VECTORS+1).
  - Wraps to 0 and op index advances when count == NUM_VECTORS-1.
  - The last vector of op 111 causes the RUN → DONE transition.
- Outside RUN:
  - alu_a = 0, alu_b = 0, alu_ctrl = 000.
  - signature holds its value.

## Timing
- Reset: state IDLE; busy=0, done=0, pass=0, signature=0, alu_a/alu_b=0, alu_ctrl=000, lfsr=SEED.
- Reset asserted mid-RUN aborts immediately to these values. No partial signature is retained.
- Vector issue:
  - start is sampled high at edge k.
  - busy=1 and the first vector appear after edge k.
  - Each vector is held exactly one cycle.
  - The ALU result is captured at the end of that cycle.
- Completion:
  - After edge k+7·NUM_VECTORS: busy=0, done=1, signature final.
  - With the check enabled, pass is valid in the same cycle.
- start held high continuously: one test runs, then another begins on the first edge in DONE.
  - done is high for exactly one cycle between tests.
- busy and done are never high simultaneously.

## Configuration
- ALU_BIST_CHECK_EN
- Defined:
  - pass is registered on the RUN → DONE edge as (sig_next == GOLDEN_SIG).
  - pass is cleared on start and on reset.
- Undefined:
  - pass is tied to 0.
  - No comparator is synthesized.
  - GOLDEN_SIG is unused.

## Test plan
- Reset: assert rst_n=0 mid-run with NUM_VECTORS=4 → all outputs return to their reset values within the reset cycle. A subsequent start gives a signature identical to a clean run.
- Basic run: NUM_VECTORS=4, behavioral ALU model, start pulsed one cycle → busy high for exactly 28 cycles, then done=1.
  - The alu_ctrl sequence is 000×4, 001×4, 010×4, 100×4, 101×4, 110×4, 111×4.
  - signature equals the bench's MISR reference model.
- Shift operands: during every cycle with alu_ctrl ∈ {001,101}, alu_b[31:5]==0. At least one shift amount is nonzero.
- Start ignored: assert start at cycle 10 of RUN → the cycle count and signature are unchanged from the basic run.
- Restart: start again from DONE → done drops, 28 busy cycles follow, and the signature is bit-identical to the first run.
- Check enabled: GOLDEN_SIG is set to the basic-run signature → pass=1. Forcing alu_result[0] inverted for one cycle → pass=0 with a different signature.

Source files
------------

// File: rtl/alu_bist.sv
// ALU built-in self-test: LFSR-driven vectors over seven opcodes, results folded into a 32-bit MISR.
// Optional golden-signature comparator enabled by defining ALU_BIST_CHECK_EN.
module alu_bist #(
  parameter int unsigned NUM_VECTORS = 64,
  parameter logic [31:0] SEED        = 32'hACE1_2345,
  parameter logic [31:0] GOLDEN_SIG  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_sign,
  output logic [31:0] signature,
  output logic        pass
);

  localparam int unsigned CW   = $clog2(NUM_VECTORS + 1);
  localparam logic [31:0] POLY = 32'h0040_0007;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e        state_q;
  logic [31:0]   lfsr_q, lfsr_d;
  logic [31:0]   sig_q, sig_d;
  logic [2:0]    op_idx_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    op;
  logic          is_shift;
  logic          last_vec;
  logic          last_op;
  logic          running;

  always_comb begin
    running  = (state_q == S_RUN);
    // opcode 011 is skipped: indices 3..6 map to 100..111
    op       = (op_idx_q < 3'd3) ? op_idx_q : op_idx_q + 3'd1;
    is_shift = (op == 3'b001) || (op == 3'b101);
    last_vec = (cnt_q == CW'(NUM_VECTORS - 1));
    last_op  = (op_idx_q == 3'd6);
    lfsr_d   = {lfsr_q[30:0], 1'b0} ^ (lfsr_q[31] ? POLY : '0);
    sig_d    = ({sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : '0))
               ^ alu_result ^ {30'b0, alu_sign, alu_zero};
  end

  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = '0;
    if (running) begin
      alu_a    = lfsr_q;
      alu_b    = is_shift ? {27'b0, lfsr_q[4:0]} : {lfsr_q[15:0], lfsr_q[31:16]};
      alu_ctrl = op;
    end
  end

`ifdef ALU_BIST_CHECK_EN
  logic pass_q;
  assign pass = pass_q;
`else
  assign pass = 1'b0;
`endif

  assign busy      = running;
  assign done      = (state_q == S_DONE);
  assign signature = sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      lfsr_q   <= SEED;
      sig_q    <= '0;
      op_idx_q <= '0;
      cnt_q    <= '0;
`ifdef ALU_BIST_CHECK_EN
      pass_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q  <= S_RUN;
            lfsr_q   <= SEED;
            sig_q    <= '0;
            op_idx_q <= '0;
            cnt_q    <= '0;
`ifdef ALU_BIST_CHECK_EN
            pass_q   <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          lfsr_q <= lfsr_d;
          sig_q  <= sig_d;
          if (last_vec) begin
            cnt_q <= '0;
            if (last_op) begin
              state_q <= S_DONE;
`ifdef ALU_BIST_CHECK_EN
              pass_q  <= (sig_d == GOLDEN_SIG);
`endif
            end else begin
              op_idx_q <= op_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// Directed bench for alu_bist with NUM_VECTORS=4, a behavioural ALU and an independent MISR model.
module tb_alu_bist;

  localparam int unsigned NV     = 4;
  localparam logic [31:0] SEED_V = 32'hACE1_2345;
  localparam logic [31:0] POLY   = 32'h0040_0007;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done, pass;
  logic [31:0] alu_a, alu_b, alu_result, signature;
  logic [2:0]  alu_ctrl;
  logic        alu_zero, alu_sign;
  logic        flip;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a << b[4:0];
      3'b010:  return a - b;
      3'b100:  return a ^ b;
      3'b101:  return a >> b[4:0];
      3'b110:  return a | b;
      3'b111:  return a & b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [2:0] exp_op(input int cyc);
    int idx;
    idx = cyc / NV;
    return (idx < 3) ? 3'(idx) : 3'(idx + 1);
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {l[30:0], 1'b0} ^ (l[31] ? POLY : 32'h0);
  endfunction

  function automatic logic [31:0] exp_b(input logic [2:0] op, input logic [31:0] l);
    if (op == 3'b001 || op == 3'b101) return {27'b0, l[4:0]};
    return {l[15:0], l[31:16]};
  endfunction

  // Independent MISR reference; flip_at selects the vector whose result bit 0 is inverted (-1: none)
  function automatic logic [31:0] model_sig(input int flip_at);
    logic [31:0] l, s, r;
    logic [2:0]  op;
    l = SEED_V;
    s = 32'h0;
    for (int i = 0; i < 7 * NV; i++) begin
      op = exp_op(i);
      r  = alu_fn(op, l, exp_b(op, l));
      if (i == flip_at) r = r ^ 32'h1;
      s  = ({s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0)) ^ r ^ {30'b0, r[31], (r == 32'h0)};
      l  = lfsr_step(l);
    end
    return s;
  endfunction

  assign alu_result = alu_fn(alu_ctrl, alu_a, alu_b) ^ {31'b0, flip};
  assign alu_zero   = (alu_result == 32'h0);
  assign alu_sign   = alu_result[31];

`ifdef ALU_BIST_CHECK_EN
  localparam logic [31:0] GOLDEN = model_sig(-1);
  alu_bist #(.NUM_VECTORS(NV), .SEED(SEED_V), .GOLDEN_SIG(GOLDEN)) dut (
`else
  alu_bist #(.NUM_VECTORS(NV), .SEED(SEED_V)) dut (
`endif
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .alu_zero(alu_zero), .alu_sign(alu_sign), .signature(signature), .pass(pass)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_sig"}, signature, 32'h0);
    chk({tag, "_a"}, alu_a, 32'h0);
    chk({tag, "_b"}, alu_b, 32'h0);
    chk({tag, "_ctrl"}, 32'(alu_ctrl), 32'd0);
  endtask

  bit shift_nonzero = 1'b0;

  // Pulse start, then follow the run, checking every applied vector against the model
  task automatic run_test(input int start_at, input int flip_at, output int cycles);
    logic [31:0] el;
    logic [2:0]  eo;
    el = SEED_V;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("run_done_dropped", 32'(done), 32'd0);
    cycles = 0;
    while (busy && cycles < 100) begin
      eo = exp_op(cycles);
      chk("vec_ctrl", 32'(alu_ctrl), 32'(eo));
      chk("vec_a", alu_a, el);
      chk("vec_b", alu_b, exp_b(eo, el));
      if (alu_ctrl == 3'b001 || alu_ctrl == 3'b101) begin
        chk("shift_b_hi", {5'b0, alu_b[31:5]}, 32'h0);
        if (alu_b[4:0] != 5'd0) shift_nonzero = 1'b1;
      end
      start = (cycles == start_at);
      flip  = (cycles == flip_at);
      el = lfsr_step(el);
      cycles++;
      @(negedge clk);
    end
    start = 1'b0;
    flip  = 1'b0;
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_done", 32'(done), 32'd1);
  endtask

  initial begin
    int cyc, n;
    logic [31:0] sig1;
    rst_n = 1'b0;
    start = 1'b0;
    flip  = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("idle");

    run_test(-1, -1, cyc);
    chk("basic_cycles", 32'(cyc), 32'd28);
    sig1 = signature;
    chk("basic_sig", sig1, model_sig(-1));
`ifdef ALU_BIST_CHECK_EN
    chk("basic_pass", 32'(pass), 32'd1);
`else
    chk("basic_pass", 32'(pass), 32'd0);
`endif
    repeat (3) @(negedge clk);
    chk("done_hold", 32'(done), 32'd1);
    chk("sig_hold", signature, sig1);

    run_test(-1, -1, cyc);
    chk("restart_cycles", 32'(cyc), 32'd28);
    chk("restart_sig", signature, sig1);

    run_test(10, -1, cyc);
    chk("ign_start_cycles", 32'(cyc), 32'd28);
    chk("ign_start_sig", signature, sig1);
    chk("shift_nonzero", 32'(shift_nonzero), 32'd1);

    run_test(-1, 5, cyc);
    chk("flip_cycles", 32'(cyc), 32'd28);
    chk("flip_sig", signature, model_sig(5));
    chk("flip_sig_differs", 32'(signature != sig1), 32'd1);
    chk("flip_pass", 32'(pass), 32'd0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("midrun_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_test(-1, -1, cyc);
    chk("post_reset_cycles", 32'(cyc), 32'd28);
    chk("post_reset_sig", signature, sig1);

    // start held high: back-to-back tests with a single done cycle in between
    start = 1'b1;
    n = 0;
    @(negedge clk);
    while (!done && n < 100) begin
      chk("held_no_overlap", 32'(busy & done), 32'd0);
      n++;
      @(negedge clk);
    end
    chk("held_first_done", 32'(done), 32'd1);
    chk("held_first_sig", signature, sig1);
    n = 0;
    while (done && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk("held_done_width", 32'(n), 32'd1);
    chk("held_rebusy", 32'(busy), 32'd1);
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("held_second_done", 32'(done), 32'd1);
    chk("held_second_sig", signature, sig1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
